seq_divider: RTL



---
 rtl/seq_divider.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// Results land in dedicated output registers that hold until the next done.
module seq_divider #(
  parameter int AW = 16,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] quotient,
  output logic [BW-1:0] remainder,
  output logic          div_by_zero,
  output logic [1:0]    state_dbg
);

  localparam int CW = $clog2(AW + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(AW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW:0]   prem_q, prem_d;
  logic [AW-1:0] dvd_q, dvd_d;
  logic [BW-1:0] dvs_q, dvs_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] quo_q, quo_d;
  logic [BW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [BW:0]   shifted;
  logic [BW:0]   trial;
  logic          fits;
  logic [BW:0]   prem_next;
  logic [AW-1:0] dvd_next;

  // The partial remainder stays below the divisor, so its top bit is only headroom.
  logic unused_prem_msb;
  assign unused_prem_msb = prem_q[BW];

  assign shifted   = {prem_q[BW-1:0], dvd_q[AW-1]};
  assign fits      = (shifted >= {1'b0, dvs_q});
  assign trial     = shifted - {1'b0, dvs_q};
  assign prem_next = fits ? trial : shifted;
  assign dvd_next  = {dvd_q[AW-2:0], fits};

  // Handshake: start is taken on a rising edge whenever busy=0 (IDLE or the
  // DONE cycle); while busy=1 it is dropped, not queued. done is a one-cycle
  // pulse and quotient/remainder/div_by_zero are valid from that cycle on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
            dvd_d   = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            rem_d   = dividend[BW-1:0];
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        prem_d = prem_next;
        dvd_d  = dvd_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          done_d  = 1'b1;
          quo_d   = dvd_next;
          rem_d   = prem_next[BW-1:0];
          dbz_d   = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule
